// File: rtl/param_seq_detector.sv
// param_seq_detector: parametrised serial bit-pattern detector.
//   Shifts in J on every edge with en=1 and pulses Y for one cycle when the
//   last PAT_LEN sampled bits equal PATTERN (MSB = first bit received).
//   overlap selects whether a hit keeps its history (overlapping matches) or
//   restarts the detector (non-overlapping). match_cnt counts hits,
//   saturating at all-ones, and is zeroed by the synchronous clear.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset of all state
//   en         sample qualifier for J
//   J          serial data bit
//   overlap    1 = overlapping matches, 0 = non-overlapping
//   clear      synchronous clear of match_cnt (wins over a same-edge hit)
//   Y          registered one-cycle match pulse
//   match_cnt  saturating match count
module param_seq_detector #(
  parameter int unsigned        PAT_LEN = 8,
  parameter logic [PAT_LEN-1:0] PATTERN = 8'b10000001,
  parameter int unsigned        CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             J,
  input  logic             overlap,
  input  logic             clear,
  output logic             Y,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned        FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               y_q, y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [PAT_LEN-1:0] nh_c;
  logic [FILL_W-1:0]  nf_c;
  logic               hit_c;

  // Candidate history/fill if this edge samples J, and the match decision.
  always_comb begin
    nh_c  = {hist_q[PAT_LEN-2:0], J};
    nf_c  = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
    // fill guard stops leading-zero patterns matching the reset history
    hit_c = en && (nf_c == FILL_FULL) && (nh_c == PATTERN);
  end

  // Next-state logic for history, fill, match pulse and counter.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    y_d    = 1'b0;
    cnt_d  = cnt_q;

    if (en) begin
      if (hit_c) begin
        y_d = 1'b1;
        if (overlap) begin
          hist_d = nh_c;
          fill_d = FILL_FULL;
        end else begin
          hist_d = '0;
          fill_d = '0;
        end
      end else begin
        hist_d = nh_c;
        fill_d = nf_c;
      end
    end

    if (clear) begin
      cnt_d = '0;
    end else if (hit_c && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
      y_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      y_q    <= y_d;
      cnt_q  <= cnt_d;
    end
  end

  assign Y         = y_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_param_seq_detector.sv
// Bench for param_seq_detector: three instances (default, CNT_W=2, and
// PAT_LEN=4 with an all-zero pattern), table-driven vectors, hand-written
// corner sequences, then random stimulus against a queue-based model.
module tb_param_seq_detector;

  typedef struct {
    logic rst;
    logic en;
    logic j;
    logic ov;
    logic clr;
    logic y;
    int   cnt;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       en_s  [3];
  logic       j_s   [3];
  logic       ov_s  [3];
  logic       clr_s [3];
  logic       y0, y1, y2;
  logic [7:0] cnt0;
  logic [1:0] cnt1;
  logic [7:0] cnt2;

  int ncmp = 0;
  int nerr = 0;

  vec_t vecs[$];

  param_seq_detector u_d0 (
    .clk(clk), .rst(rst), .en(en_s[0]), .J(j_s[0]), .overlap(ov_s[0]),
    .clear(clr_s[0]), .Y(y0), .match_cnt(cnt0));

  param_seq_detector #(.PAT_LEN(8), .PATTERN(8'b10000001), .CNT_W(2)) u_d1 (
    .clk(clk), .rst(rst), .en(en_s[1]), .J(j_s[1]), .overlap(ov_s[1]),
    .clear(clr_s[1]), .Y(y1), .match_cnt(cnt1));

  param_seq_detector #(.PAT_LEN(4), .PATTERN(4'b0000), .CNT_W(8)) u_d2 (
    .clk(clk), .rst(rst), .en(en_s[2]), .J(j_s[2]), .overlap(ov_s[2]),
    .clear(clr_s[2]), .Y(y2), .match_cnt(cnt2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: keep the last (up to) L bits sampled since the last
  // restart; a hit is L bits present that spell the pattern.
  int unsigned mlen [3] = '{8, 8, 4};
  logic [31:0] mpat [3] = '{32'h81, 32'h81, 32'h0};
  int          mmax [3] = '{255, 3, 255};
  bit          mq   [3][$];
  logic        ey   [3];
  int          ec   [3];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        mq[i].delete();
        ey[i] <= 1'b0;
        ec[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        automatic bit hit = 1'b0;
        if (en_s[i]) begin
          mq[i].push_back(j_s[i]);
          if (mq[i].size() > mlen[i]) void'(mq[i].pop_front());
          if (mq[i].size() == mlen[i]) begin
            hit = 1'b1;
            for (int k = 0; k < int'(mlen[i]); k++)
              if (mq[i][k] != mpat[i][int'(mlen[i]) - 1 - k]) hit = 1'b0;
          end
          if (hit && !ov_s[i]) mq[i].delete();
        end
        ey[i] <= hit;
        if (clr_s[i])                 ec[i] <= 0;
        else if (hit && ec[i] < mmax[i]) ec[i] <= ec[i] + 1;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drv(input int k, input logic e, input logic j, input logic o, input logic c);
    en_s[k] = e; j_s[k] = j; ov_s[k] = o; clr_s[k] = c;
  endtask

  task automatic add(input logic r, input logic e, input logic j, input logic o,
                     input logic c, input logic y, input int cnt);
    vec_t v;
    v.rst = r; v.en = e; v.j = j; v.ov = o; v.clr = c; v.y = y; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  // n bits of v, MSB first; ymask marks bits after which Y is expected.
  task automatic add_bits(input logic [31:0] v, input int n, input logic o,
                          input logic [31:0] ymask, inout int cnt);
    for (int k = n - 1; k >= 0; k--) begin
      if (ymask[k]) cnt++;
      add(1'b1, 1'b1, v[k], o, 1'b0, ymask[k], cnt);
    end
  endtask

  initial begin
    int c;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) drv(i, 1'b0, 1'b0, 1'b1, 1'b0);

    // Overlapping 15-bit stream: hits after bits 8 and 15.
    c = 0; add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    add_bits(32'b100000010000001, 15, 1'b1, 32'b000000010000001, c);
    // Same stream, non-overlapping: only the first hit.
    c = 0; add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    add_bits(32'b100000010000001, 15, 1'b0, 32'b000000010000000, c);
    // Enable gap keeps the partial match.
    c = 0; add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    add_bits(32'b1000, 4, 1'b1, 32'b0, c);
    for (int k = 0; k < 3; k++) add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    add_bits(32'b0001, 4, 1'b1, 32'b0001, c);
    // Reset mid-pattern discards history.
    c = 0; add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    add_bits(32'b1000000, 7, 1'b1, 32'b0, c);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    add_bits(32'b1, 1, 1'b1, 32'b0, c);
    add_bits(32'b10000001, 8, 1'b1, 32'b00000001, c);
    // Overlapping hit with clear on the same edge: Y pulses, count zeroed.
    add_bits(32'b000000, 6, 1'b1, 32'b0, c);
    add(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0);
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      drv(0, vecs[i].en, vecs[i].j, vecs[i].ov, vecs[i].clr);
      tick();
      check($sformatf("tbl%0d_y", i), 32'(y0), 32'(vecs[i].y));
      check($sformatf("tbl%0d_cnt", i), 32'(cnt0), 32'(vecs[i].cnt));
    end
    drv(0, 1'b0, 1'b0, 1'b1, 1'b0);

    // CNT_W=2: saturation, clear on a hit, then count resumes.
    rst = 1'b0; tick();
    check("d1_rst_y", 32'(y1), 32'd0);
    check("d1_rst_cnt", 32'(cnt1), 32'd0);
    rst = 1'b1;
    for (int m = 0; m < 7; m++) begin
      logic [7:0] pat;
      pat = 8'b10000001;
      for (int k = 7; k >= 0; k--) begin
        drv(1, 1'b1, pat[k], 1'b0, (m == 5 && k == 0) ? 1'b1 : 1'b0);
        tick();
        check($sformatf("d1_m%0d_b%0d_y", m, k), 32'(y1), (k == 0) ? 32'd1 : 32'd0);
      end
      check($sformatf("d1_m%0d_cnt", m), 32'(cnt1),
            (m < 5) ? 32'(m < 2 ? m + 1 : 3) : ((m == 5) ? 32'd0 : 32'd1));
    end
    drv(1, 1'b0, 1'b0, 1'b1, 1'b0);

    // All-zero 4-bit pattern: no match before four bits are sampled.
    rst = 1'b0; tick();
    rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      drv(2, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      check($sformatf("d2_b%0d_y", k), 32'(y2), (k >= 4) ? 32'd1 : 32'd0);
      check($sformatf("d2_b%0d_cnt", k), 32'(cnt2), (k >= 4) ? 32'(k - 3) : 32'd0);
    end
    drv(2, 1'b0, 1'b0, 1'b1, 1'b0);

    // Random traffic on all instances against the model.
    rst = 1'b0; tick();
    rst = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 3; i++)
        drv(i, ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 63) == 0));
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 399) == 0) rst = 1'b0;
      tick();
      check("rnd_d0_y", 32'(y0), 32'(ey[0]));
      check("rnd_d0_cnt", 32'(cnt0), 32'(ec[0]));
      check("rnd_d1_y", 32'(y1), 32'(ey[1]));
      check("rnd_d1_cnt", 32'(cnt1), 32'(ec[1]));
      check("rnd_d2_y", 32'(y2), 32'(ey[2]));
      check("rnd_d2_cnt", 32'(cnt2), 32'(ec[2]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/param_seq_detector.md
Name: param_seq_detector

Overview:
- Parametrised serial bit-pattern detector. It generalises the fixed 10000001 detectors to any pattern and length.
- Adds a runtime-selectable overlap mode, an input-enable qualifier, and a saturating match counter with synchronous clear.
- Sits on the serial input path (J) and drives a one-cycle match pulse (Y) plus a match count for downstream control/status logic.

Parameters:
- PAT_LEN, 8, pattern length in bits; legal range 2..32.
- PATTERN, 8'b10000001, target pattern of PAT_LEN bits; MSB is the first bit received.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; rst=0 clears all state immediately.
- en  input  1  sample qualifier; J is consumed only on edges where en=1.
- J  input  1  serial data bit.
- overlap  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
- clear  input  1  synchronous clear of match_cnt only.
- Y  output  1  registered match pulse.
- match_cnt  output  CNT_W  saturating count of matches since reset/clear.

Behaviour:
- Reset (rst=0, asynchronous): history register = 0, fill counter = 0, Y = 0, match_cnt = 0. Nothing updates while rst=0.
- State:
  - hist[PAT_LEN-1:0]: shift register; newest bit enters at bit 0, oldest bit is at the MSB.
  - fill: saturating count 0..PAT_LEN of valid bits in hist.
- Edge with en=1:
  - nh = {hist[PAT_LEN-2:0], J}.
  - nf = min(fill+1, PAT_LEN).
  - hit = (nf == PAT_LEN) && (nh == PATTERN).
- On hit:
  - Y <= 1.
  - overlap=1: hist <= nh, fill <= PAT_LEN.
  - overlap=0: hist <= 0, fill <= 0. The next match needs PAT_LEN fresh bits.
- Edge with en=1 and no hit: hist <= nh, fill <= nf, Y <= 0.
- Edge with en=0: hist and fill hold, Y <= 0, and J is ignored. Enable gaps do not break a partial match.
- Latency: Y is high for exactly the one cycle after the edge that samples the final pattern bit. Consecutive hits give consecutive Y pulses.
- overlap is sampled on each hit edge; changing it mid-stream affects only subsequent hits.
- match_cnt:
  - Increments on each hit edge and saturates at 2^CNT_W-1 with no wrap.
  - clear=1 forces match_cnt <= 0 and takes priority over a simultaneous hit.
  - Y still pulses on that hit, and the hit is not counted.
- A detector restart requires rst. clear does not touch hist, fill or Y.
- Reset asserted mid-pattern discards all partial history; the pattern must be received in full after rst deasserts.
- Matches that need fewer than PAT_LEN sampled bits since reset or a non-overlap restart are impossible, even when PATTERN has leading zeros.

Test Plan:
- Default params, overlap=1, en=1. After reset, J = 1,0,0,0,0,0,0,1,0,0,0,0,0,0,1 (15 bits) -> Y pulses after bit 8 and after bit 15; match_cnt = 2.
- Same 15-bit stream with overlap=0 -> single Y pulse after bit 8; match_cnt = 1.
- Enable gap: J = 1,0,0,0, then 3 cycles of en=0 with J=1, then J = 0,0,0,1 with en=1 -> one Y pulse after the final 1, none during the gap; match_cnt = 1.
- Reset mid-operation: feed 1,0,0,0,0,0,0, pulse rst=0 for one cycle, then J=1 -> Y stays 0 and match_cnt = 0. Then feeding 10000001 -> Y = 1 once.
- Saturation/clear with CNT_W=2: 5 non-overlapping matches -> match_cnt = 3. Assert clear on the edge of a 6th hit -> Y = 1 and match_cnt = 0. A 7th hit -> match_cnt = 1.
- PAT_LEN=4, PATTERN=4'b0000, overlap=1: J = 0 for 6 bits from reset -> no Y for the first 3 bits, Y high for 3 consecutive cycles (after bits 4, 5, 6); match_cnt = 3.
